// File: rtl/cc_viterbi_dec.sv
// Hard-decision Viterbi decoder, K=7 rate-1/2 (G1=171 on X, G2=133 on Y).
// 64-state ACS array with register-exchange survivors, zero-tail flush.
// Optional build macro CC_VIT_BEST_STATE_EN: RUN-phase output follows the
// minimum-metric state instead of state 0.

// One add-compare-select unit for trellis state NXT.
module cc_vit_acs #(
  parameter int         PM_W = 6,
  parameter int         SW   = 31,
  parameter logic [5:0] NXT  = '0
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [SW-1:0]   sv0,
  input  logic [SW-1:0]   sv1,
  input  logic [1:0]      rx,
  input  logic [1:0]      er,
  output logic [PM_W-1:0] pm_n,
  output logic [SW-1:0]   sv_n,
  output logic            old_bit
);
  // predecessors differ only in s[5]; input bit is the new state's LSB
  localparam logic [5:0] P0 = {1'b0, NXT[5:1]};
  localparam logic [5:0] P1 = {1'b1, NXT[5:1]};
  localparam logic       B  = NXT[0];
  localparam logic [1:0] E0 = {B ^ P0[1] ^ P0[2] ^ P0[4] ^ P0[5],
                               B ^ P0[0] ^ P0[1] ^ P0[2] ^ P0[5]};
  localparam logic [1:0] E1 = {B ^ P1[1] ^ P1[2] ^ P1[4] ^ P1[5],
                               B ^ P1[0] ^ P1[1] ^ P1[2] ^ P1[5]};

  function automatic logic [PM_W-1:0] bm(input logic [1:0] e, input logic [1:0] r,
                                         input logic [1:0] x);
    logic [1:0] m;
    m  = ~x & (e ^ r);
    bm = PM_W'(m[0]) + PM_W'(m[1]);
  endfunction

  logic [PM_W-1:0] c0, c1, d;
  logic            take1;
  logic [SW-1:0]   sv_sel;

  // modulo compare: take pred 1 only when strictly smaller, so ties go to s[5]=0
  always_comb begin
    c0      = pm0 + bm(E0, rx, er);
    c1      = pm1 + bm(E1, rx, er);
    d       = c1 - c0;
    take1   = d[PM_W-1];
    pm_n    = take1 ? c1 : c0;
    sv_sel  = take1 ? sv1 : sv0;
    sv_n    = {sv_sel[SW-2:0], B};
    old_bit = sv_sel[SW-1];
  end
endmodule

module cc_viterbi_dec #(
  parameter int TB_DEPTH = 32,
  parameter int PM_W     = 6,
  parameter int LEN_W    = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] in_pair,
  input  logic [1:0] in_erase,
  input  logic       in_valid,
  input  logic       in_start,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_bit,
  output logic       out_valid,
  output logic       out_last
);
  localparam int NS = 64;
  // stored survivors drop the oldest bit: it only ever feeds the RUN output,
  // which is taken from the freshly computed survivor (old_bit)
  localparam int SW = TB_DEPTH - 1;
  localparam int FW = $clog2(TB_DEPTH - 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [PM_W-1:0]  PM_INIT = PM_W'(2 ** (PM_W - 2));
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  logic [1:0]                  state;
  logic [NS-1:0][PM_W-1:0]     pm_q, pm_src, pm_d;
  logic [NS-1:0][SW-1:0]       sv_q, sv_src, sv_d;
  logic [NS-1:0]               old_bit;
  logic [LEN_W-1:0]            cnt_q, k_next;
  logic [FW-1:0]               fidx, fidx_init;
  logic [5:0]                  best;
  logic                        acc, start_acc, run_emit, run_bit;

  assign in_ready  = (state != FLUSH);
  assign acc       = in_valid & in_ready & ((state != IDLE) | in_start);
  assign start_acc = acc & in_start;

  // ACS inputs: a frame start re-seeds the trellis ahead of this pair's ACS
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      pm_src[i] = pm_q[i];
      sv_src[i] = sv_q[i];
      if (start_acc) begin
        pm_src[i] = (i == 0) ? '0 : PM_INIT;
        sv_src[i] = '0;
      end
    end
  end

  for (genvar g = 0; g < NS; g++) begin : g_acs
    cc_vit_acs #(.PM_W(PM_W), .SW(SW), .NXT(6'(g))) u_acs (
      .pm0     (pm_src[g / 2]),
      .pm1     (pm_src[g / 2 + NS / 2]),
      .sv0     (sv_src[g / 2]),
      .sv1     (sv_src[g / 2 + NS / 2]),
      .rx      (in_pair),
      .er      (in_erase),
      .pm_n    (pm_d[g]),
      .sv_n    (sv_d[g]),
      .old_bit (old_bit[g])
    );
  end

`ifdef CC_VIT_BEST_STATE_EN
  logic [PM_W-1:0] best_pm, diff;

  // minimum-metric search over new metrics; strict '<' keeps the lowest index on ties
  always_comb begin
    best    = '0;
    best_pm = pm_d[0];
    diff    = '0;
    for (int i = 1; i < NS; i++) begin
      diff = pm_d[i] - best_pm;
      if (diff[PM_W-1]) begin
        best    = 6'(i);
        best_pm = pm_d[i];
      end
    end
  end
`else
  logic unused_old_bits;
  assign best            = '0;
  assign unused_old_bits = ^old_bit[NS-1:1];
`endif

  assign run_bit = old_bit[best];

  // pair count (saturating), RUN emit decision and flush start index
  always_comb begin
    if (start_acc)             k_next = LEN_W'(1);
    else if (cnt_q == CNT_MAX) k_next = cnt_q;
    else                       k_next = cnt_q + 1'b1;
    run_emit  = acc && (k_next >= LEN_W'(TB_DEPTH));
    fidx_init = (k_next < LEN_W'(TB_DEPTH - 1)) ? FW'(k_next - 1'b1) : FW'(TB_DEPTH - 2);
  end

  // trellis update on accept, frame FSM and output strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pm_q      <= '0;
      sv_q      <= '0;
      cnt_q     <= '0;
      fidx      <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (acc) begin
        pm_q  <= pm_d;
        sv_q  <= sv_d;
        cnt_q <= k_next;
        state <= in_last ? FLUSH : RUN;
        if (in_last) fidx <= fidx_init;
        if (run_emit) begin
          out_valid <= 1'b1;
          out_bit   <= run_bit;
        end
      end else if (state == FLUSH) begin
        // tail has driven the encoder to state 0: drain its survivor oldest-first
        out_valid <= 1'b1;
        out_bit   <= sv_q[0][fidx];
        fidx      <= fidx - 1'b1;
        if (fidx == '0) begin
          out_last <= 1'b1;
          state    <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_cc_viterbi_dec.sv
// Bench for cc_viterbi_dec: random info frames are convolutionally encoded
// here (generator-polynomial parity), optionally punctured / corrupted, and
// the decoded stream must reproduce the info+tail bits.
module tb_cc_viterbi_dec;
  localparam int TB_DEPTH = 32;
  localparam int PM_W     = 6;
  localparam int LEN_W    = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] in_pair = '0;
  logic [1:0] in_erase = '0;
  logic       in_valid = 1'b0;
  logic       in_start = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready, out_bit, out_valid, out_last;

  cc_viterbi_dec #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .in_pair(in_pair), .in_erase(in_erase),
    .in_valid(in_valid), .in_start(in_start), .in_last(in_last),
    .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // stimulus and expected-output queues
  logic [1:0] pr_q[$];
  logic [1:0] er_q[$];
  bit         st_q[$];
  bit         ls_q[$];
  bit         exp_q[$];

  task automatic new_frame();
    pr_q.delete(); er_q.delete(); st_q.delete(); ls_q.delete(); exp_q.delete();
  endtask

  // kind: 0 all-zero, 1 impulse, 2 random; punct applies rate-3/4 erasures
  task automatic mk_frame(input int ninfo, input int kind, input int ntail, input bit punct);
    logic [6:0] hist;
    logic [1:0] p, e;
    bit         b;
    int         n;
    hist = '0;
    n = ninfo + ntail;
    for (int i = 0; i < n; i++) begin
      b = 1'b0;
      if (i < ninfo) begin
        if (kind == 2)                b = 1'($urandom);
        else if (kind == 1 && i == 0) b = 1'b1;
      end
      hist = {b, hist[6:1]};
      p[0] = ^(hist & 7'o171);
      p[1] = ^(hist & 7'o133);
      e = 2'b00;
      if (punct) begin
        if (i % 3 == 1)      e = 2'b10;
        else if (i % 3 == 2) e = 2'b01;
      end
      p = p ^ (e & 2'($urandom));
      pr_q.push_back(p); er_q.push_back(e);
      st_q.push_back(i == 0); ls_q.push_back(i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  // output monitor, sampled on the falling edge
  bit got_q[$];
  int last_cnt, last_idx, busy, acc_cnt, ncyc, acc_cyc, first_ov;

  always @(negedge clk) begin
    ncyc++;
    if (out_valid) begin
      if (first_ov < 0) first_ov = ncyc;
      got_q.push_back(out_bit);
      if (out_last) begin
        last_cnt++;
        last_idx = got_q.size() - 1;
      end
    end
    if (!in_ready) busy++;
    if (in_valid && in_ready) begin
      acc_cnt++;
      if (acc_cnt == TB_DEPTH) acc_cyc = ncyc;
    end
  end

  task automatic clr();
    got_q.delete();
    last_cnt = 0; last_idx = -1; busy = 0; acc_cnt = 0; acc_cyc = -1; first_ov = -1;
  endtask

  task automatic drive(input int n, input bit gaps, input bit junk);
    if (junk) repeat ($urandom_range(1, 3)) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_start = 1'b0; in_last = 1'($urandom); in_pair = 2'($urandom);
    end
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b1; in_pair = pr_q[i]; in_erase = er_q[i];
      in_start = st_q[i]; in_last = ls_q[i];
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0; in_erase = '0;
  endtask

  task automatic check_frame(input string tag, input int npairs);
    int t, errs, r;
    t = 0; errs = 0;
    r = (npairs < TB_DEPTH - 1) ? npairs : TB_DEPTH - 1;
    while (last_cnt == 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk({tag, "_done"}, longint'(t < 3000), 1);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] != exp_q[i]) errs++;
    chk({tag, "_bit_errs"}, errs, 0);
    chk({tag, "_last_cnt"}, last_cnt, 1);
    chk({tag, "_last_pos"}, last_idx, exp_q.size() - 1);
    chk({tag, "_flush_cyc"}, busy, r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] tmp;
    int         n;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // all-zero 64-pair frame, latency of first output
    new_frame(); mk_frame(58, 0, 6, 0); clr();
    drive(64, 0, 0);
    check_frame("zero", 64);
    chk("zero_latency", first_ov, acc_cyc + 1);

    // impulse response
    new_frame(); mk_frame(64, 1, 6, 0); clr();
    drive(70, 1, 1);
    check_frame("impulse", 70);

    // impulse with X of pair 3 flipped
    new_frame(); mk_frame(64, 1, 6, 0);
    tmp = pr_q[2]; tmp[0] = ~tmp[0]; pr_q[2] = tmp;
    clr();
    drive(70, 1, 1);
    check_frame("impulse_err", 70);

    // random 200 info bits, rate-3/4 puncturing via erasures
    new_frame(); mk_frame(200, 2, 6, 1); clr();
    drive(206, 1, 1);
    check_frame("punct", 206);

    // random rate-1/2 frames of assorted length
    for (int f = 0; f < 3; f++) begin
      n = $urandom_range(8, 120);
      new_frame(); mk_frame(n, 2, 6, 0); clr();
      drive(n + 6, 1, 1);
      check_frame("rand", n + 6);
    end

    // frame shorter than the survivor depth: all bits come from flush
    new_frame(); mk_frame(14, 2, 6, 0); clr();
    drive(20, 1, 1);
    check_frame("short", 20);

    // single-pair frame: start and last together
    new_frame(); mk_frame(1, 0, 0, 0); clr();
    drive(1, 0, 1);
    check_frame("one_pair", 1);

    // reset in the middle of a frame
    new_frame(); mk_frame(94, 2, 6, 0); clr();
    drive(40, 0, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clr();
    repeat (20) @(posedge clk);
    #1;
    chk("mid_rst_quiet", got_q.size(), 0);
    new_frame(); mk_frame(94, 2, 6, 0); clr();
    drive(100, 1, 1);
    check_frame("post_rst", 100);

    // new start at pair 50 truncates the running frame
    new_frame(); mk_frame(94, 2, 6, 0);
    while (pr_q.size() > 49) begin
      void'(pr_q.pop_back()); void'(er_q.pop_back());
      void'(st_q.pop_back()); void'(ls_q.pop_back());
    end
    while (exp_q.size() > 49 - TB_DEPTH + 1) void'(exp_q.pop_back());
    mk_frame(74, 2, 6, 0);
    clr();
    drive(129, 1, 1);
    check_frame("restart", 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
